// File: rtl/em_pipe_reg.sv
// E->M pipeline register: captures execute-stage results, merges execute-stage
// overflow into the carried exception code and counts Tnew down for the hazard unit.
module em_pipe_reg #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [4:0]  EXC_OV     = 5'd12,
   parameter logic [4:0]  EXC_ADEL   = 5'd4,
   parameter logic [4:0]  EXC_ADES   = 5'd5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] instr_E,
   input  logic [31:0] pc_E,
   input  logic        bd_E,
   input  logic [4:0]  exccode_E,
   input  logic [31:0] alu_c_E,
   input  logic        cal_overflow_E,
   input  logic [1:0]  ov_kind_E,
   input  logic [31:0] hi_E,
   input  logic [31:0] lo_E,
   input  logic [1:0]  res_sel_E,
   input  logic [31:0] rt_data_E,
   input  logic [4:0]  wa_E,
   input  logic [1:0]  tnew_E,
   output logic [31:0] instr_M,
   output logic [31:0] pc_M,
   output logic        bd_M,
   output logic [4:0]  exccode_M,
   output logic [31:0] addr_M,
   output logic [31:0] result_M,
   output logic [31:0] wdata_M,
   output logic [4:0]  wa_M,
   output logic [1:0]  tnew_M
);

   logic [31:0] result_next;
   logic [4:0]  exccode_next;
   logic [4:0]  wa_next;
   logic [1:0]  tnew_next;
   logic        new_ov;

   // Result select, exception merge, Ov kill and Tnew countdown.
   always_comb begin
      result_next  = alu_c_E;
      exccode_next = 5'd0;
      new_ov       = 1'b0;

      unique case (res_sel_E)
         2'd0: result_next = alu_c_E;
         2'd1: result_next = hi_E;
         2'd2: result_next = lo_E;
         2'd3: result_next = pc_E + 32'd8;
      endcase

      // Upstream exceptions always take priority over execute-stage overflow.
      if (exccode_E != 5'd0) begin
         exccode_next = exccode_E;
      end else if (cal_overflow_E) begin
         unique case (ov_kind_E)
            2'd0: exccode_next = 5'd0;
            2'd1: begin
               exccode_next = EXC_OV;
               new_ov       = 1'b1;
            end
            2'd2: exccode_next = EXC_ADEL;
            2'd3: exccode_next = EXC_ADES;
         endcase
      end

      // Only a freshly raised Ov kills the write here; AdEL/AdES are suppressed downstream.
      wa_next   = new_ov ? 5'd0 : wa_E;
      tnew_next = (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
   end

   // Pipeline register: reset > flush request > capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_M   <= 32'd0;
         pc_M      <= 32'd0;
         bd_M      <= 1'b0;
         exccode_M <= 5'd0;
         addr_M    <= 32'd0;
         result_M  <= 32'd0;
         wdata_M   <= 32'd0;
         wa_M      <= 5'd0;
         tnew_M    <= 2'd0;
      end else if (req) begin
         instr_M   <= 32'd0;
         pc_M      <= HANDLER_PC;
         bd_M      <= 1'b0;
         exccode_M <= 5'd0;
         addr_M    <= 32'd0;
         result_M  <= 32'd0;
         wdata_M   <= 32'd0;
         wa_M      <= 5'd0;
         tnew_M    <= 2'd0;
      end else begin
         instr_M   <= instr_E;
         pc_M      <= pc_E;
         bd_M      <= bd_E;
         exccode_M <= exccode_next;
         addr_M    <= alu_c_E;
         result_M  <= result_next;
         wdata_M   <= rt_data_E;
         wa_M      <= wa_next;
         tnew_M    <= tnew_next;
      end
   end

endmodule

// File: tb/tb_em_pipe_reg.sv
// Self-checking bench for em_pipe_reg: directed steps plus a short random run,
// expected outputs queued at drive time and compared one cycle later.
module tb_em_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, req, bd_E, cal_overflow_E;
   logic [31:0] instr_E, pc_E, alu_c_E, hi_E, lo_E, rt_data_E;
   logic [4:0]  exccode_E, wa_E;
   logic [1:0]  ov_kind_E, res_sel_E, tnew_E;
   logic [31:0] instr_M, pc_M, addr_M, result_M, wdata_M;
   logic        bd_M;
   logic [4:0]  exccode_M, wa_M;
   logic [1:0]  tnew_M;

   typedef struct {
      string       name;
      logic [31:0] instr, pc, addr, result, wdata;
      logic        bd;
      logic [4:0]  exccode, wa;
      logic [1:0]  tnew;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   em_pipe_reg dut (
      .clk(clk), .reset(reset), .req(req), .instr_E(instr_E), .pc_E(pc_E), .bd_E(bd_E),
      .exccode_E(exccode_E), .alu_c_E(alu_c_E), .cal_overflow_E(cal_overflow_E),
      .ov_kind_E(ov_kind_E), .hi_E(hi_E), .lo_E(lo_E), .res_sel_E(res_sel_E),
      .rt_data_E(rt_data_E), .wa_E(wa_E), .tnew_E(tnew_E), .instr_M(instr_M), .pc_M(pc_M),
      .bd_M(bd_M), .exccode_M(exccode_M), .addr_M(addr_M), .result_M(result_M),
      .wdata_M(wdata_M), .wa_M(wa_M), .tnew_M(tnew_M)
   );

   // Reference behaviour computed from the currently driven inputs.
   function automatic exp_t model(string name);
      exp_t e;
      e.name = name;
      e.instr = 0; e.pc = 0; e.addr = 0; e.result = 0; e.wdata = 0;
      e.bd = 0; e.exccode = 0; e.wa = 0; e.tnew = 0;
      if (reset) return e;
      if (req) begin
         e.pc = 32'h0000_4180;
         return e;
      end
      e.instr = instr_E; e.pc = pc_E; e.bd = bd_E; e.addr = alu_c_E; e.wdata = rt_data_E;
      case (res_sel_E)
         2'd0: e.result = alu_c_E;
         2'd1: e.result = hi_E;
         2'd2: e.result = lo_E;
         default: e.result = pc_E + 32'd8;
      endcase
      e.wa = wa_E;
      if (exccode_E != 0) e.exccode = exccode_E;
      else if (cal_overflow_E) begin
         case (ov_kind_E)
            2'd1: begin e.exccode = 5'd12; e.wa = 5'd0; end
            2'd2: e.exccode = 5'd4;
            2'd3: e.exccode = 5'd5;
            default: e.exccode = 5'd0;
         endcase
      end
      e.tnew = (tnew_E == 0) ? 2'd0 : tnew_E - 2'd1;
      return e;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue the expectation, clock once, then compare the M outputs.
   task automatic step(string name);
      exp_t e;
      sb.push_back(model(name));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s: scoreboard empty observed 0 expected 1", name);
         return;
      end
      e = sb.pop_front();
      check({e.name, ".instr_M"},   instr_M,   e.instr);
      check({e.name, ".pc_M"},      pc_M,      e.pc);
      check({e.name, ".bd_M"},      {31'd0, bd_M},      {31'd0, e.bd});
      check({e.name, ".exccode_M"}, {27'd0, exccode_M}, {27'd0, e.exccode});
      check({e.name, ".addr_M"},    addr_M,    e.addr);
      check({e.name, ".result_M"},  result_M,  e.result);
      check({e.name, ".wdata_M"},   wdata_M,   e.wdata);
      check({e.name, ".wa_M"},      {27'd0, wa_M},      {27'd0, e.wa});
      check({e.name, ".tnew_M"},    {30'd0, tnew_M},    {30'd0, e.tnew});
   endtask

   task automatic rand_inputs();
      instr_E = $urandom; pc_E = $urandom; bd_E = 1'($urandom);
      exccode_E = 5'($urandom_range(0, 3) == 0 ? $urandom : 0);
      alu_c_E = $urandom; cal_overflow_E = 1'($urandom); ov_kind_E = 2'($urandom);
      hi_E = $urandom; lo_E = $urandom; res_sel_E = 2'($urandom);
      rt_data_E = $urandom; wa_E = 5'($urandom); tnew_E = 2'($urandom);
   endtask

   task automatic clean();
      instr_E = 32'h0000_0000; pc_E = 32'h0000_3000; bd_E = 0; exccode_E = 0;
      alu_c_E = 0; cal_overflow_E = 0; ov_kind_E = 0; hi_E = 0; lo_E = 0;
      res_sel_E = 0; rt_data_E = 32'h1234_5678; wa_E = 0; tnew_E = 0;
   endtask

   initial begin
      reset = 1; req = 0;
      rand_inputs();
      step("reset0");
      rand_inputs();
      step("reset1");
      // Direct reset-state check against constants.
      check("rst.pc_M_zero", pc_M, 32'd0);
      check("rst.result_M_zero", result_M, 32'd0);

      reset = 0;
      clean();
      instr_E = 32'h0085_1021; alu_c_E = 7; wa_E = 2; tnew_E = 1;
      step("first");
      check("first.result_7", result_M, 32'd7);

      clean();
      hi_E = 32'hAAAA_0000; lo_E = 32'h0000_5555; pc_E = 32'h0000_3010;
      res_sel_E = 1; step("sel_hi");
      res_sel_E = 2; step("sel_lo");
      res_sel_E = 3; step("sel_pc8");
      check("sel_pc8.const", result_M, 32'h0000_3018);
      pc_E = 32'hFFFF_FFFC; step("sel_pc8_wrap");
      check("wrap.const", result_M, 32'h0000_0004);

      clean();
      wa_E = 8; cal_overflow_E = 1;
      ov_kind_E = 1; step("ov_arith");
      check("ov_arith.wa0", {27'd0, wa_M}, 32'd0);
      ov_kind_E = 2; step("ov_load");
      ov_kind_E = 3; step("ov_store");
      ov_kind_E = 0; step("ov_none");

      exccode_E = 5'd10; ov_kind_E = 1; wa_E = 3; step("upstream");
      check("upstream.code10", {27'd0, exccode_M}, 32'd10);

      clean();
      instr_E = 32'h0085_2820; alu_c_E = 32'h55; wa_E = 5; bd_E = 1; tnew_E = 1;
      req = 1; step("flush");
      check("flush.handler", pc_M, 32'h0000_4180);
      reset = 1; step("flush_reset");
      reset = 0; req = 0;

      clean();
      wa_E = 4;
      tnew_E = 2; step("tnew2");
      tnew_E = 1; step("tnew1");
      tnew_E = 0; step("tnew0");

      for (int i = 0; i < 60; i++) begin
         rand_inputs();
         req = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
